// File: rtl/comparator_iterative_if.sv
// Operand/result bundle for comparator_iterative: request channel in, result channel out.
// Both channels transfer on a clock edge where valid & ready are high; valid may not depend on ready.
interface comparator_iterative_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic [1:0]   op;
  logic         o_valid;
  logic         o_ready;
  logic         out;
  logic         lt;
  logic         eq;

  modport master (
    output i_valid, a, b, is_signed, op, o_ready,
    input  i_ready, o_valid, out, lt, eq
  );

  modport slave (
    input  i_valid, a, b, is_signed, op, o_ready,
    output i_ready, o_valid, out, lt, eq
  );
endinterface

// File: rtl/comparator_iterative.sv
// Multi-cycle magnitude comparator: walks the operands W bits per cycle, MSB chunk first,
// and reports lt/eq plus one selected relation behind valid/ready handshakes.
module comparator_iterative #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  comparator_iterative_if.slave bus,
  output logic [1:0]           state_dbg
);
  localparam int CHUNKS = N / W;
  localparam int CW     = $clog2(CHUNKS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_LT = 2'd0;
  localparam logic [1:0] OP_LE = 2'd1;
  localparam logic [1:0] OP_EQ = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  logic [N-1:0]  flip;
  logic [1:0]    op_r;
  logic [CW-1:0] cnt;
  logic          decided;
  logic          lt_r;
  logic          out_r;
  logic          lt_o;
  logic          eq_o;

  logic [W-1:0]  chunk_a;
  logic [W-1:0]  chunk_b;
  logic          decided_next;
  logic          lt_next;
  logic          last_chunk;
  logic          res_lt;
  logic          res_eq;
  logic          res_out;
  logic          accept;
  logic          retire;

  always_comb begin
    accept     = (state == IDLE) && bus.i_valid;
    retire     = (state == DONE) && bus.o_ready;
    chunk_a    = ra[N-1 -: W];
    chunk_b    = rb[N-1 -: W];
    last_chunk = (cnt == CW'(1));

    // The first differing chunk from the top fixes the ordering; later chunks cannot change it.
    decided_next = decided;
    lt_next      = lt_r;
    if (!decided && (chunk_a != chunk_b)) begin
      decided_next = 1'b1;
      lt_next      = (chunk_a < chunk_b);
    end

    res_lt = lt_next;
    res_eq = !decided_next;
    case (op_r)
      OP_LT:   res_out = res_lt;
      OP_LE:   res_out = res_lt | res_eq;
      OP_EQ:   res_out = res_eq;
      default: res_out = !res_lt & !res_eq;
    endcase

    // Flipping the sign bit maps two's complement order onto unsigned order.
    flip      = '0;
    flip[N-1] = bus.is_signed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      op_r    <= OP_LT;
      cnt     <= '0;
      decided <= 1'b0;
      lt_r    <= 1'b0;
      out_r   <= 1'b0;
      lt_o    <= 1'b0;
      eq_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ra      <= bus.a ^ flip;
            rb      <= bus.b ^ flip;
            op_r    <= bus.op;
            cnt     <= CW'(CHUNKS);
            decided <= 1'b0;
            lt_r    <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          decided <= decided_next;
          lt_r    <= lt_next;
          ra      <= ra << W;
          rb      <= rb << W;
          cnt     <= cnt - CW'(1);
          // Fixed latency: every chunk is visited even once the answer is known.
          if (last_chunk) begin
            state <= DONE;
            out_r <= res_out;
            lt_o  <= res_lt;
            eq_o  <= res_eq;
          end
        end
        DONE: begin
          if (retire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.out     = out_r;
  assign bus.lt      = lt_o;
  assign bus.eq      = eq_o;
  assign state_dbg   = state;
endmodule

// File: tb/tb_comparator_iterative.sv
// Bench for comparator_iterative: directed cases on (32,8) plus a randomized sweep over
// four (N,W) configurations checked against an arithmetic reference model.
module tb_comparator_iterative;
  localparam logic [1:0] OP_LT = 2'd0;
  localparam logic [1:0] OP_LE = 2'd1;
  localparam logic [1:0] OP_EQ = 2'd2;
  localparam logic [1:0] OP_GT = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic        s_valid = 1'b0;
  logic        s_o_ready = 1'b0;
  logic        s_signed = 1'b0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic [1:0]  s_op = 2'd0;

  logic [3:0] v_i_ready, v_o_valid, v_out, v_lt, v_eq;
  logic [1:0] v_state [4];
  logic       c_i_ready, c_o_valid, c_out, c_lt, c_eq;

  int tests_run = 0;
  int tests_failed = 0;
  logic [2:0] exp_q[$];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int NN = (k == 3) ? 12 : 32;
    localparam int WW = (k == 0) ? 8 : (k == 1) ? 1 : (k == 2) ? 32 : 4;
    comparator_iterative_if #(.N(NN)) bus ();
    assign bus.i_valid   = s_valid && (sel == 2'(k));
    assign bus.o_ready   = s_o_ready && (sel == 2'(k));
    assign bus.a         = s_a[NN-1:0];
    assign bus.b         = s_b[NN-1:0];
    assign bus.is_signed = s_signed;
    assign bus.op        = s_op;
    assign v_i_ready[k]  = bus.i_ready;
    assign v_o_valid[k]  = bus.o_valid;
    assign v_out[k]      = bus.out;
    assign v_lt[k]       = bus.lt;
    assign v_eq[k]       = bus.eq;
    comparator_iterative #(.N(NN), .W(WW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (v_state[k])
    );
  end

  always_comb begin
    c_i_ready = v_i_ready[sel];
    c_o_valid = v_o_valid[sel];
    c_out     = v_out[sel];
    c_lt      = v_lt[sel];
    c_eq      = v_eq[sel];
  end

  // Reference: interpret the low n bits as integers and compare them arithmetically.
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input int n, input logic sgn, input logic [1:0] op);
    longint va, vb;
    logic l, e, o;
    va = longint'(a) & ((longint'(1) << n) - 1);
    vb = longint'(b) & ((longint'(1) << n) - 1);
    if (sgn && a[n-1]) va = va - (longint'(1) << n);
    if (sgn && b[n-1]) vb = vb - (longint'(1) << n);
    l = (va < vb);
    e = (va == vb);
    case (op)
      OP_LT:   o = l;
      OP_LE:   o = l || e;
      OP_EQ:   o = e;
      default: o = (va > vb);
    endcase
    return {o, l, e};
  endfunction

  // Issue one operation and wait for o_valid; lat counts edges from accept to o_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [1:0] op, output int lat);
    int guard;
    s_a = a; s_b = b; s_signed = sgn; s_op = op; s_valid = 1'b1;
    guard = 0;
    while (!c_i_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_a = $urandom; s_b = $urandom; s_op = 2'($urandom); s_signed = 1'($urandom);
    lat = 0;
    while (!c_o_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op();
    s_o_ready = 1'b1;
    @(posedge clk); #1;
    s_o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if (v_i_ready !== 4'hF || v_o_valid !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_handshake: i_ready=%b o_valid=%b, expected 1111/0000", v_i_ready, v_o_valid);
    end
    tests_run++;
    if ((v_out | v_lt | v_eq) !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: out=%b lt=%b eq=%b, expected all 0", v_out, v_lt, v_eq);
    end
    tests_run++;
    if ((v_state[0] | v_state[1] | v_state[2] | v_state[3]) !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: some state_dbg nonzero, expected idle (0)");
    end
  endtask

  task automatic check_result(input string name, input int lat, input logic [2:0] exp);
    tests_run++;
    if (lat !== 4 || {c_out, c_lt, c_eq} !== exp) begin
      tests_failed++;
      $display("FAIL %s: lat=%0d {out,lt,eq}=%b, expected lat=4 %b", name, lat, {c_out, c_lt, c_eq}, exp);
    end
  endtask

  task automatic test_signedness();
    int lat;
    sel = 2'd0;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, OP_LT, lat);
    check_result("signed_lt", lat, 3'b110);
    finish_op();
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_LT, lat);
    check_result("unsigned_lt", lat, 3'b000);
    finish_op();
  endtask

  task automatic test_equal();
    int lat;
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, OP_LE, lat);
    check_result("equal_le", lat, 3'b101);
    finish_op();
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, OP_LT, lat);
    check_result("equal_lt", lat, 3'b001);
    finish_op();
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, OP_EQ, lat);
    check_result("equal_eq", lat, 3'b101);
    finish_op();
  endtask

  task automatic test_last_chunk();
    int lat;
    run_op(32'h1234_5678, 32'h1234_5679, 1'b0, OP_LT, lat);
    check_result("last_chunk_lt", lat, 3'b110);
    finish_op();
    run_op(32'h1234_5679, 32'h1234_5678, 1'b0, OP_GT, lat);
    check_result("last_chunk_gt", lat, 3'b100);
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'd5, 32'd3, 1'b0, OP_GT, lat);
    check_result("bp_first", lat, 3'b100);
    s_valid = 1'b1; s_a = 32'd1; s_b = 32'd9; s_op = OP_LT;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (c_o_valid !== 1'b1 || c_i_ready !== 1'b0 || {c_out, c_lt, c_eq} !== 3'b100) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: o_valid=%b i_ready=%b {out,lt,eq}=%b, expected 1 0 100",
                 i, c_o_valid, c_i_ready, {c_out, c_lt, c_eq});
      end
    end
    s_valid = 1'b0;
    finish_op();
    tests_run++;
    if (c_o_valid !== 1'b0 || c_i_ready !== 1'b1 || {c_out, c_lt, c_eq} !== 3'b100) begin
      tests_failed++;
      $display("FAIL bp_release: o_valid=%b i_ready=%b {out,lt,eq}=%b, expected 0 1 100",
               c_o_valid, c_i_ready, {c_out, c_lt, c_eq});
    end
    run_op(32'd3, 32'd5, 1'b0, OP_LE, lat);
    check_result("bp_next", lat, 3'b110);
    finish_op();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    run_op(32'd1, 32'd2, 1'b0, OP_LT, lat);
    check_result("pre_reset", lat, 3'b110);
    finish_op();
    s_a = 32'd1; s_b = 32'd2; s_signed = 1'b0; s_op = OP_LT; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (c_o_valid !== 1'b0 || c_i_ready !== 1'b1 || {c_out, c_lt, c_eq} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_busy_reset: o_valid=%b i_ready=%b {out,lt,eq}=%b, expected 0 1 000",
               c_o_valid, c_i_ready, {c_out, c_lt, c_eq});
    end
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (c_o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_busy_discard: o_valid=%b, expected 0", c_o_valid);
    end
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, OP_GT, lat);
    check_result("post_reset_signed", lat, 3'b100);
    finish_op();
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, OP_GT, lat);
    check_result("post_reset_unsigned", lat, 3'b010);
    finish_op();
  endtask

  task automatic test_random_sweep();
    for (int k = 0; k < 4; k++) begin
      int n, accepted, results;
      n = (k == 3) ? 12 : 32;
      sel = 2'(k);
      accepted = 0;
      results = 0;
      for (int i = 0; i < 60; i++) begin
        logic [31:0] a, b;
        logic [2:0]  got_v, exp_v;
        logic        sgn;
        logic [1:0]  op;
        int          guard, bsel;
        bit          got;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        a = $urandom;
        bsel = $urandom_range(0, 3);
        if (bsel == 0)      b = a;
        else if (bsel == 1) b = a ^ (32'd1 << $urandom_range(0, n - 1));
        else                b = $urandom;
        sgn = 1'($urandom);
        op = 2'($urandom);
        exp_q.push_back(model(a, b, n, sgn, op));
        s_a = a; s_b = b; s_signed = sgn; s_op = op; s_valid = 1'b1;
        guard = 0;
        while (!c_i_ready && guard < 100) begin
          @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_a = $urandom; s_b = $urandom;
        accepted++;
        got = 0;
        guard = 0;
        got_v = '0;
        while (!got && guard < 200) begin
          s_o_ready = 1'($urandom_range(0, 1));
          if (c_o_valid && s_o_ready) begin
            got_v = {c_out, c_lt, c_eq};
            got = 1;
          end
          @(posedge clk); #1;
          guard++;
        end
        s_o_ready = 1'b0;
        tests_run++;
        if (!got) begin
          tests_failed++;
          $display("FAIL sweep%0d_timeout op%0d: no result within 200 cycles, expected one", k, i);
        end else begin
          results++;
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin
            tests_failed++;
            $display("FAIL sweep%0d_result op%0d: a=%h b=%h s=%b op=%0d {out,lt,eq}=%b, expected %b",
                     k, i, a, b, sgn, op, got_v, exp_v);
          end
        end
        tests_run++;
        if (c_o_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL sweep%0d_dup op%0d: o_valid=%b after handshake, expected 0", k, i, c_o_valid);
        end
      end
      tests_run++;
      if (results != accepted || exp_q.size() != 0) begin
        tests_failed++;
        $display("FAIL sweep%0d_count: results=%0d pending=%0d, expected %0d and 0",
                 k, results, exp_q.size(), accepted);
      end
      exp_q.delete();
    end
    sel = 2'd0;
  endtask

  initial begin
    test_reset();
    test_signedness();
    test_equal();
    test_last_chunk();
    test_backpressure();
    test_reset_mid_busy();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
